// File: rtl/trace_pkg.sv
// Shared types and constants for the writeback trace unit.
// Latency: n/a (package only).
// Backpressure: n/a; holds the FSM encoding, the IO register map and the trace entry width helper.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_t;

  // IO offsets from IO_BASE. They are 9 bits wide so that an ID below the
  // base wraps to a large value and falls outside the window.
  localparam logic [8:0] OFS_CTRL    = 9'd0;
  localparam logic [8:0] OFS_TRIG_LO = 9'd1;
  localparam logic [8:0] OFS_TRIG_HI = 9'd2;
  localparam logic [8:0] OFS_COUNT   = 9'd3;
  localparam logic [8:0] OFS_RIDX    = 9'd4;
  localparam logic [8:0] OFS_B0      = 9'd5;
  localparam logic [8:0] OFS_B1      = 9'd6;
  localparam logic [8:0] OFS_B2      = 9'd7;
  localparam logic [8:0] OFS_B3      = 9'd8;
  localparam logic [8:0] OFS_WIN     = 9'd9;

  // CTRL write bit positions
  localparam int CTRL_ARM   = 0;
  localparam int CTRL_WRAP  = 1;
  localparam int CTRL_CLEAR = 2;
  localparam int CTRL_STOP  = 3;

  localparam int ENTRY_BITS = 32;

  // Packed width of the {pc, addr, data} fields inside one entry.
  function automatic int entry_w(input int pc_w, input int raddr_w, input int data_w);
    return pc_w + raddr_w + data_w;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace entry storage: DEPTH x 32 bits, contents are not reset.
// Latency: write lands at the clock edge; read is combinational on raddr.
// Backpressure: none; one write and one read every cycle.
// Ports: clk, we/waddr/wdata (sync write), raddr/rdata (async read).
module trace_ram
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [ENTRY_BITS-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [ENTRY_BITS-1:0] rdata
);

  logic [ENTRY_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/regwb_trace_unit.sv
// Register-writeback trace capture with optional PC trigger, read back over the 8-bit IO bus.
// Latency: an event is stored and counted at the edge it is presented; IO reads are combinational.
// Backpressure: none; events arriving in IDLE/DONE, or ARMED without a trigger match, are dropped.
// Ports: clk/reset, wb_* writeback snoop, IO_* port bus, trace_active/trace_done status.
module regwb_trace_unit
  import trace_pkg::*;
#(
  parameter int         DATA_W  = 16,
  parameter int         RADDR_W = 4,
  parameter int         PC_W    = 10,
  parameter int         DEPTH   = 16,
  parameter logic [7:0] IO_BASE = 8'hF0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wb_en,
  input  logic               wb_invalid,
  input  logic [RADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic [PC_W-1:0]    wb_pc,
  input  logic [7:0]         IO_port_ID,
  input  logic [7:0]         IO_write_data,
  input  logic               IO_write_strobe,
  input  logic               IO_read_strobe,
  output logic [7:0]         IO_read_data,
  output logic               trace_active,
  output logic               trace_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = entry_w(PC_W, RADDR_W, DATA_W);
  localparam logic [31:0] PC_MASK = 32'((64'd1 << PC_W) - 64'd1);

  trace_state_t    state;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   ridx;
  logic [CW-1:0]   count;
  logic            wrapped;
  logic            full;
  logic            mode_wrap;
  logic [7:0]      trig_lo;
  logic [7:0]      trig_hi;   // bit7 = trigger enable, [6:0] = PC[14:8]

  // IO decode
  logic [8:0] io_ofs;
  logic       ctrl_wr, do_clear, do_arm, do_stop;
  assign io_ofs   = {1'b0, IO_port_ID} - {1'b0, IO_BASE};
  assign ctrl_wr  = IO_write_strobe && (io_ofs == OFS_CTRL);
  assign do_clear = ctrl_wr && IO_write_data[CTRL_CLEAR];
  assign do_arm   = ctrl_wr && IO_write_data[CTRL_ARM] && !do_clear;
  assign do_stop  = ctrl_wr && IO_write_data[CTRL_STOP] && !do_clear && !do_arm;

  // Trigger compare; PC bits above PC_W are masked out of the trigger value.
  logic [31:0] trig_pc;
  logic        trig_match;
  assign trig_pc    = {17'd0, trig_hi[6:0], trig_lo} & PC_MASK;
  assign trig_match = (32'(wb_pc) == trig_pc);

  // An arm/clear in the same cycle discards the event; otherwise it is judged
  // against the pre-edge state.
  logic wb_event, cap_ok;
  assign wb_event = wb_en && !wb_invalid;
  assign cap_ok   = wb_event && !do_clear && !do_arm &&
                    ((state == ST_CAPTURE) || ((state == ST_ARMED) && trig_match));

  logic [EW-1:0]         wb_fields;
  logic [ENTRY_BITS-1:0] wr_entry, rd_entry;
  logic [AW-1:0]         rd_idx;
  assign wb_fields = {wb_pc, wb_addr, wb_data};
  assign wr_entry  = ENTRY_BITS'(wb_fields);
  // Once wrapped, the oldest entry sits at wr_ptr, so RIDX 0 is always oldest.
  assign rd_idx    = (wrapped ? wr_ptr : '0) + ridx;

  trace_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (cap_ok),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_idx),
    .rdata (rd_entry)
  );

  always_comb begin
    IO_read_data = 8'h00;
    case (io_ofs)
      OFS_CTRL:    IO_read_data = {4'b0, wrapped, full, state};
      OFS_TRIG_LO: IO_read_data = trig_lo;
      OFS_TRIG_HI: IO_read_data = trig_hi;
      OFS_COUNT:   IO_read_data = 8'(count);
      OFS_RIDX:    IO_read_data = 8'(ridx);
      OFS_B0:      IO_read_data = rd_entry[7:0];
      OFS_B1:      IO_read_data = rd_entry[15:8];
      OFS_B2:      IO_read_data = rd_entry[23:16];
      OFS_B3:      IO_read_data = rd_entry[31:24];
      default:     IO_read_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      ridx      <= '0;
      count     <= '0;
      wrapped   <= 1'b0;
      full      <= 1'b0;
      mode_wrap <= 1'b0;
      trig_lo   <= 8'h00;
      trig_hi   <= 8'h00;
    end else begin
      if (IO_write_strobe && (io_ofs == OFS_TRIG_LO)) trig_lo <= IO_write_data;
      if (IO_write_strobe && (io_ofs == OFS_TRIG_HI)) trig_hi <= IO_write_data;

      // Explicit RIDX write wins over the auto-increment from a byte-3 read.
      if (IO_write_strobe && (io_ofs == OFS_RIDX))
        ridx <= IO_write_data[AW-1:0];
      else if (IO_read_strobe && (io_ofs == OFS_B3))
        ridx <= ridx + AW'(1);

      if (do_clear) begin
        state   <= ST_IDLE;
        wr_ptr  <= '0;
        count   <= '0;
        wrapped <= 1'b0;
        full    <= 1'b0;
        ridx    <= '0;
      end else if (do_arm) begin
        mode_wrap <= IO_write_data[CTRL_WRAP];
        wr_ptr    <= '0;
        count     <= '0;
        wrapped   <= 1'b0;
        full      <= 1'b0;
        state     <= trig_hi[7] ? ST_ARMED : ST_CAPTURE;
      end else begin
        if (cap_ok) begin
          // A trigger hit is stored at wr_ptr 0 through the same path as any capture.
          if (state == ST_ARMED) state <= ST_CAPTURE;
          wr_ptr <= wr_ptr + AW'(1);
          if (mode_wrap) begin
            if (count != CW'(DEPTH)) count <= count + CW'(1);
            if (wr_ptr == AW'(DEPTH - 1)) wrapped <= 1'b1;
          end else begin
            count <= count + CW'(1);
            if (count == CW'(DEPTH - 1)) begin
              state <= ST_DONE;
              full  <= 1'b1;
            end
          end
        end
        if (do_stop && (state == ST_CAPTURE)) state <= ST_DONE;
      end
    end
  end

  assign trace_active = (state == ST_ARMED) || (state == ST_CAPTURE);
  assign trace_done   = (state == ST_DONE);

endmodule
